group3_pwm_capture: RTL and testbench
=====================================

Name: group3_pwm_capture

Overview:
- Measures an incoming pulse train, such as the output of the lab frequency divider or an external PWM/encoder line. Reports period and high time in IN-clock cycles.
- The receive-side complement of the divider: the divider turns divisor/divisor2 into a waveform; this block recovers both numbers from a waveform.
- Feeds speed/duty readback in the motor-control path.

Parameters:
- WIDTH, 16: width of period/high counters and outputs.
- MAXCNT, 2**WIDTH-1: period count at which a missing edge is declared a timeout.

Ports:
- IN  input  1  system clock; all logic on posedge IN.
- RST  input  1  reset, asynchronous, active-high.
- EN  input  1  measurement enable; 0 forces idle.
- SIG  input  1  measured signal; asynchronous to IN.
- PERIOD  output  WIDTH  last measured rising-to-rising interval, in IN cycles.
- HIGH  output  WIDTH  last measured high time, in IN cycles.
- VALID  output  1  one-cycle strobe; PERIOD/HIGH updated this cycle.
- TIMEOUT  output  1  sticky flag: no rising edge within MAXCNT cycles.

Behaviour:
- The clock is IN. The reset is RST, one clock domain, with asynchronous active-high reset.
- Reset values:
  - sync flops and edge flop 0
  - period_cnt and high_cnt 0
  - state IDLE
  - PERIOD=0, HIGH=0, VALID=0, TIMEOUT=0
- Input conditioning:
  - SIG passes through a 2-flop synchronizer to give s.
  - prev <= s.
  - rise = s & ~prev. A SIG edge reaches rise 3 IN cycles after sampling.
- States:
  - IDLE: wait for the first rise. On rise: go to MEAS, period_cnt<=1, high_cnt<=1. No VALID.
  - MEAS, on rise:
    - PERIOD<=period_cnt, HIGH<=high_cnt.
    - VALID<=1 and TIMEOUT<=0.
    - period_cnt<=1, high_cnt<=1.
    - Stay in MEAS.
  - MEAS, no rise:
    - If period_cnt==MAXCNT, go to STALL and set TIMEOUT<=1.
    - Otherwise period_cnt<=period_cnt+1, and high_cnt<=high_cnt+s.
  - STALL: counters hold and PERIOD/HIGH hold. On rise: go to MEAS, counters<=1, no VALID (the interval is invalid). TIMEOUT stays 1 until the next VALID.
- Resulting values: for a signal with rises every P cycles and high for H cycles, PERIOD=P and HIGH=H exactly. 1<=HIGH<=PERIOD always holds, so high_cnt cannot overflow separately.
- VALID: high exactly one cycle, registered. The first VALID comes on the second rise after entering MEAS, about P+3 cycles after the first SIG rise.
- EN=0, dominant over everything:
  - state<=IDLE, counters<=0, VALID<=0.
  - PERIOD/HIGH/TIMEOUT hold.
  - The synchronizer keeps running, so re-enable produces no false edge beyond a genuine level change.
- Simultaneous rise and period_cnt==MAXCNT: rise wins. PERIOD=MAXCNT is latched with VALID and no timeout.
- Constant SIG (0 or 1) in MEAS: TIMEOUT after MAXCNT cycles. No VALID.
- RST mid-measurement: immediate return to reset values, with no VALID.
- Glitches shorter than one IN cycle may be missed. No debounce.
- Widths: all counters are WIDTH bits, unsigned. There is no wrap-around, because STALL replaces it.

Test Plan:
- Same-clock divider source (divisor=200, divisor2=100) on SIG with EN=1:
  - After the 2nd rise, VALID pulses with PERIOD=200 and HIGH=100.
  - Repeats every 200 cycles, with no TIMEOUT.
- Duty sweep, P=50 with H=1, then H=25, then H=49:
  - Each VALID reports PERIOD=50 and HIGH equal to that H.
  - The first VALID after a change reflects the new H exactly.
- WIDTH=8 with SIG held low after one rise:
  - TIMEOUT=1 at 255 cycles after the rise.
  - Then P=10/H=5 resumes: the first rise gives no VALID, the second gives VALID with PERIOD=10 and HIGH=5, and TIMEOUT clears.
- WIDTH=8 with the rise landing exactly when period_cnt==255: VALID, PERIOD=255, TIMEOUT stays 0.
- EN dropped mid-period for 20 cycles, then raised:
  - No VALID while EN=0, and PERIOD/HIGH hold.
  - The first post-enable rise gives no VALID; the next gives a correct measurement.
- RST asserted asynchronously between clock edges mid-measurement:
  - All outputs are 0 immediately.
  - After release, the first VALID appears only after two fresh rises.

Source files
------------

// File: rtl/group3_pwm_capture.sv
// Pulse-train capture: measures rising-to-rising period and high time
// of an asynchronous input in IN-clock cycles, with a sticky timeout.
module group3_pwm_capture #(
    parameter int WIDTH  = 16,
    parameter int MAXCNT = 2**WIDTH-1
) (
    input  logic             IN,
    input  logic             RST,
    input  logic             EN,
    input  logic             SIG,
    output logic [WIDTH-1:0] PERIOD,
    output logic [WIDTH-1:0] HIGH,
    output logic             VALID,
    output logic             TIMEOUT
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MEAS,
        S_STALL
    } state_t;

    localparam logic [WIDTH-1:0] LP_MAX = WIDTH'(MAXCNT);
    localparam logic [WIDTH-1:0] LP_ONE = WIDTH'(1);

    logic             r_sync1;
    logic             r_sync;
    logic             r_prev;
    logic             w_rise;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_pcnt;
    logic [WIDTH-1:0] r_hcnt;
    logic [WIDTH-1:0] w_pcnt_nxt;
    logic [WIDTH-1:0] w_hcnt_nxt;
    logic [WIDTH-1:0] w_per_nxt;
    logic [WIDTH-1:0] w_high_nxt;
    logic             w_valid_nxt;
    logic             w_to_nxt;

    // Synchronizer and edge flop run regardless of EN so re-enable is clean
    always_ff @(posedge IN or posedge RST) begin
        if (RST) begin
            r_sync1 <= 1'b0;
            r_sync  <= 1'b0;
            r_prev  <= 1'b0;
        end else begin
            r_sync1 <= SIG;
            r_sync  <= r_sync1;
            r_prev  <= r_sync;
        end
    end

    assign w_rise = r_sync & ~r_prev;

    always_ff @(posedge IN or posedge RST) begin
        if (RST) begin
            r_state <= S_IDLE;
            r_pcnt  <= '0;
            r_hcnt  <= '0;
            PERIOD  <= '0;
            HIGH    <= '0;
            VALID   <= 1'b0;
            TIMEOUT <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pcnt  <= w_pcnt_nxt;
            r_hcnt  <= w_hcnt_nxt;
            PERIOD  <= w_per_nxt;
            HIGH    <= w_high_nxt;
            VALID   <= w_valid_nxt;
            TIMEOUT <= w_to_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pcnt_nxt  = r_pcnt;
        w_hcnt_nxt  = r_hcnt;
        w_per_nxt   = PERIOD;
        w_high_nxt  = HIGH;
        w_valid_nxt = 1'b0;
        w_to_nxt    = TIMEOUT;
        if (!EN) begin
            w_state_nxt = S_IDLE;
            w_pcnt_nxt  = '0;
            w_hcnt_nxt  = '0;
        end else begin
            unique case (r_state)
                S_IDLE, S_STALL: begin
                    if (w_rise) begin
                        w_state_nxt = S_MEAS;
                        w_pcnt_nxt  = LP_ONE;
                        w_hcnt_nxt  = LP_ONE;
                    end
                end
                S_MEAS: begin
                    // A rise on the terminal count still yields a measurement
                    if (w_rise) begin
                        w_per_nxt   = r_pcnt;
                        w_high_nxt  = r_hcnt;
                        w_valid_nxt = 1'b1;
                        w_to_nxt    = 1'b0;
                        w_pcnt_nxt  = LP_ONE;
                        w_hcnt_nxt  = LP_ONE;
                    end else if (r_pcnt == LP_MAX) begin
                        w_state_nxt = S_STALL;
                        w_to_nxt    = 1'b1;
                    end else begin
                        w_pcnt_nxt = r_pcnt + LP_ONE;
                        w_hcnt_nxt = r_hcnt + WIDTH'(r_sync);
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_group3_pwm_capture.sv
// Bench for group3_pwm_capture: edge-index reference model checked every
// cycle, plus directed literal checks on the key scenarios.
module tb_group3_pwm_capture;

    localparam int W    = 8;
    localparam int MAXC = 255;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en  = 1'b0;
    logic         sig = 1'b0;
    logic [W-1:0] period;
    logic [W-1:0] high;
    logic         valid;
    logic         timeout;

    group3_pwm_capture #(
        .WIDTH (W),
        .MAXCNT(MAXC)
    ) dut (
        .IN     (clk),
        .RST    (rst),
        .EN     (en),
        .SIG    (sig),
        .PERIOD (period),
        .HIGH   (high),
        .VALID  (valid),
        .TIMEOUT(timeout)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: remembers the edge index of the last rise and the
    // number of high samples since then; SIG reaches the detector 2 edges late.
    bit           smp[3];
    int           edge_n    = 0;
    int           last_rise = 0;
    int           hi_sum    = 0;
    bit           measuring = 1'b0;
    bit           stalled   = 1'b0;
    bit           m_s;
    bit           m_rise;
    logic [W-1:0] m_per   = '0;
    logic [W-1:0] m_high  = '0;
    logic         m_valid = 1'b0;
    logic         m_to    = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            smp       = '{1'b0, 1'b0, 1'b0};
            measuring = 1'b0;
            stalled   = 1'b0;
            hi_sum    = 0;
            m_per     = '0;
            m_high    = '0;
            m_valid   = 1'b0;
            m_to      = 1'b0;
        end else begin
            edge_n++;
            m_s    = smp[1];
            m_rise = smp[1] && !smp[2];
            smp[2] = smp[1];
            smp[1] = smp[0];
            smp[0] = sig;
            m_valid = 1'b0;
            if (!en) begin
                measuring = 1'b0;
                stalled   = 1'b0;
            end else if (m_rise) begin
                if (measuring && !stalled) begin
                    m_valid = 1'b1;
                    m_per   = W'(edge_n - last_rise);
                    m_high  = W'(hi_sum);
                    m_to    = 1'b0;
                end
                measuring = 1'b1;
                stalled   = 1'b0;
                last_rise = edge_n;
                hi_sum    = 1;
            end else if (measuring && !stalled) begin
                if (edge_n - last_rise == MAXC) begin
                    stalled = 1'b1;
                    m_to    = 1'b1;
                end else begin
                    hi_sum += int'(m_s);
                end
            end
        end
    end

    bit           chk_on    = 1'b0;
    int           nvalid    = 0;
    logic [W-1:0] last_per  = '0;
    logic [W-1:0] last_high = '0;

    always @(negedge clk) begin
        if (chk_on && !rst) begin
            n_vec++;
            if ({valid, timeout, period, high} !==
                {m_valid, m_to, m_per, m_high}) begin
                n_bad++;
                $display("FAIL cycle t=%0t got v=%b to=%b p=%0d h=%0d required v=%b to=%b p=%0d h=%0d",
                         $time, valid, timeout, period, high,
                         m_valid, m_to, m_per, m_high);
            end
            if (valid === 1'b1) begin
                nvalid++;
                last_per  = period;
                last_high = high;
            end
        end
    end

    task automatic check(input string name, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    task automatic pwm(input int p, input int h, input int ncyc,
                       input int off_at, input int off_len);
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            sig = ((c % p) < h);
            en  = !(off_at >= 0 && c >= off_at && c < off_at + off_len);
        end
    endtask

    task automatic hold(input bit v, input int ncyc);
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            sig = v;
        end
    endtask

    int nv0;
    int rp;
    int rh;

    initial begin
        repeat (3) @(negedge clk);
        check("rst_period", int'(period), 0);
        check("rst_high", int'(high), 0);
        check("rst_valid", int'(valid), 0);
        check("rst_timeout", int'(timeout), 0);
        rst    = 1'b0;
        en     = 1'b1;
        chk_on = 1'b1;

        nv0 = nvalid;
        pwm(200, 100, 800, -1, 0);
        check("div_period", int'(last_per), 200);
        check("div_high", int'(last_high), 100);
        check("div_count", nvalid - nv0, 3);
        check("div_timeout", int'(timeout), 0);

        pwm(50, 1, 150, -1, 0);
        check("duty1_high", int'(last_high), 1);
        check("duty1_period", int'(last_per), 50);
        pwm(50, 25, 150, -1, 0);
        check("duty25_high", int'(last_high), 25);
        pwm(50, 49, 150, -1, 0);
        check("duty49_high", int'(last_high), 49);

        hold(1'b1, 5);
        hold(1'b0, 300);
        check("stall_timeout", int'(timeout), 1);
        nv0 = nvalid;
        pwm(10, 5, 30, -1, 0);
        check("resume_count", nvalid - nv0, 2);
        check("resume_period", int'(last_per), 10);
        check("resume_high", int'(last_high), 5);
        check("resume_timeout", int'(timeout), 0);

        pwm(255, 5, 520, -1, 0);
        check("max_period", int'(last_per), 255);
        check("max_timeout", int'(timeout), 0);

        nv0 = nvalid;
        pwm(40, 10, 200, 50, 20);
        check("en_count", nvalid - nv0, 4);
        check("en_period", int'(last_per), 40);
        check("en_high", int'(last_high), 10);

        pwm(30, 12, 45, -1, 0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_period", int'(period), 0);
        check("arst_high", int'(high), 0);
        check("arst_valid", int'(valid), 0);
        check("arst_timeout", int'(timeout), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        nv0 = nvalid;
        pwm(30, 12, 90, -1, 0);
        check("arst_count", nvalid - nv0, 2);
        check("arst_meas_period", int'(last_per), 30);
        check("arst_meas_high", int'(last_high), 12);

        for (int k = 0; k < 25; k++) begin
            rp = int'($urandom_range(80, 2));
            rh = int'($urandom_range(rp - 1, 1));
            if ($urandom_range(3, 0) == 0)
                pwm(rp, rh, rp * int'($urandom_range(4, 1)),
                    int'($urandom_range(rp, 0)), int'($urandom_range(25, 1)));
            else
                pwm(rp, rh, rp * int'($urandom_range(4, 1)), -1, 0);
        end

        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            sig = 1'($urandom_range(1, 0));
        end
        hold(1'b1, 300);
        check("high_timeout", int'(timeout), 1);
        hold(1'b0, 20);
        pwm(17, 6, 60, -1, 0);

        @(negedge clk);
        chk_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
